// File: rtl/mdio_arbiter_if.sv
// Controller-side bus between mdio_arbiter and the MDIO management controller.
//   activado     : controller enable, high for the whole transaction
//   mdio_start   : 1-cycle start pulse
//   t_data       : 32-bit Clause-22 frame
//   mdio_done    : controller completion pulse
//   ctrl_rd_data : controller read data, valid with mdio_done
// master = arbiter side, slave = controller side.
interface mdio_arbiter_if;
  localparam int unsigned FRAME_W = 32;
  localparam int unsigned DATA_W  = 16;

  logic               activado;
  logic               mdio_start;
  logic [FRAME_W-1:0] t_data;
  logic               mdio_done;
  logic [DATA_W-1:0]  ctrl_rd_data;

  modport master (
    output activado, mdio_start, t_data,
    input  mdio_done, ctrl_rd_data
  );

  modport slave (
    input  activado, mdio_start, t_data,
    output mdio_done, ctrl_rd_data
  );
endinterface

// File: rtl/mdio_arbiter.sv
// Round-robin arbiter sharing one MDIO management controller between N_REQ
// requesters. Builds the Clause-22 frame, pulses mdio_start, waits for
// mdio_done and returns done/err/rd_data to the winning requester.
// Ports:
//   clk, reset (synchronous, active-high)
//   req/req_op/req_phy/req_reg/req_wdata : per-requester request and fields
//   gnt, done (one-hot pulses), err, rd_data, busy : requester side
//   mdio (mdio_arbiter_if.master) : controller start/done interface
// Optional: define MDIO_TIMEOUT_EN to abort a transaction after TIMEOUT_CYC
// WAIT cycles without mdio_done.
module mdio_arbiter #(
  parameter int unsigned N_REQ       = 4,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [N_REQ-1:0]      req,
  input  logic [2*N_REQ-1:0]    req_op,
  input  logic [5*N_REQ-1:0]    req_phy,
  input  logic [5*N_REQ-1:0]    req_reg,
  input  logic [16*N_REQ-1:0]   req_wdata,
  output logic [N_REQ-1:0]      gnt,
  output logic [N_REQ-1:0]      done,
  output logic                  err,
  output logic [15:0]           rd_data,
  output logic                  busy,
  mdio_arbiter_if.master        mdio
);

  localparam int unsigned IDX_W = $clog2(N_REQ);
  localparam logic [1:0]  OP_WR = 2'b01;
  localparam logic [1:0]  OP_RD = 2'b10;

  // Parameter sanity check at elaboration.
  if (N_REQ < 2 || N_REQ > 8 || TIMEOUT_CYC < 2) begin : g_bad_param
    $error("mdio_arbiter: N_REQ must be 2..8 and TIMEOUT_CYC >= 2");
  end

  typedef enum logic [1:0] {IDLE, WAIT, GAP} state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               rd_q, rd_d;
  logic [N_REQ-1:0]   gnt_q, gnt_d;
  logic [N_REQ-1:0]   done_q, done_d;
  logic               err_q, err_d;
  logic [15:0]        rd_data_q, rd_data_d;
  logic               busy_q, busy_d;
  logic               act_q, act_d;
  logic               start_q, start_d;
  logic [31:0]        t_data_q, t_data_d;

`ifdef MDIO_TIMEOUT_EN
  localparam int unsigned CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
`endif

  // Round-robin pick: first set req bit searching upward from ptr with wrap.
  logic               found_c;
  logic [IDX_W-1:0]   win_c;
  logic [IDX_W-1:0]   ptr_next_c;
  logic [1:0]         op_c;
  logic [4:0]         phy_c;
  logic [4:0]         reg_c;
  logic [15:0]        wdata_c;

  always_comb begin : rr_pick
    found_c = 1'b0;
    win_c   = ptr_q;
    for (int k = 0; k < int'(N_REQ); k++) begin
      int j;
      j = int'(ptr_q) + k;
      if (j >= int'(N_REQ)) j = j - int'(N_REQ);
      if (!found_c && req[IDX_W'(j)]) begin
        found_c = 1'b1;
        win_c   = IDX_W'(j);
      end
    end
    ptr_next_c = (win_c == IDX_W'(N_REQ - 1)) ? '0 : win_c + 1'b1;
    op_c       = req_op[2*win_c +: 2];
    phy_c      = req_phy[5*win_c +: 5];
    reg_c      = req_reg[5*win_c +: 5];
    wdata_c    = req_wdata[16*win_c +: 16];
  end

  // Next-state and registered-output logic.
  always_comb begin : fsm_next
    state_d   = state_q;
    ptr_d     = ptr_q;
    idx_d     = idx_q;
    rd_d      = rd_q;
    gnt_d     = '0;
    done_d    = '0;
    err_d     = 1'b0;
    rd_data_d = rd_data_q;
    busy_d    = busy_q;
    act_d     = act_q;
    start_d   = 1'b0;
    t_data_d  = t_data_q;
`ifdef MDIO_TIMEOUT_EN
    cnt_d     = cnt_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (found_c) begin
          gnt_d    = N_REQ'(1) << win_c;
          busy_d   = 1'b1;
          ptr_d    = ptr_next_c;
          idx_d    = win_c;
          rd_d     = (op_c == OP_RD);
          t_data_d = {2'b01, op_c, phy_c, reg_c, 2'b10,
                      (op_c == OP_WR) ? wdata_c : 16'h0000};
`ifdef MDIO_TIMEOUT_EN
          cnt_d    = '0;
`endif
          if (op_c == OP_WR || op_c == OP_RD) begin
            start_d = 1'b1;
            act_d   = 1'b1;
            state_d = WAIT;
          end else begin
            state_d = GAP;
          end
        end
      end

      // mdio_done is ignored while the start pulse is still high.
      WAIT: begin
        if (!start_q && mdio.mdio_done) begin
          done_d  = N_REQ'(1) << idx_q;
          act_d   = 1'b0;
          if (rd_q) rd_data_d = mdio.ctrl_rd_data;
          state_d = GAP;
        end
`ifdef MDIO_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
          done_d  = N_REQ'(1) << idx_q;
          err_d   = 1'b1;
          act_d   = 1'b0;
          state_d = GAP;
        end else begin
          cnt_d   = cnt_q + 1'b1;
        end
`endif
      end

      // A bad opcode enters GAP with done still low: raise done/err first,
      // then spend the normal one-cycle done window here.
      GAP: begin
        if (done_q == '0) begin
          done_d = N_REQ'(1) << idx_q;
          err_d  = 1'b1;
        end else begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin : regs
    if (reset) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      idx_q     <= '0;
      rd_q      <= 1'b0;
      gnt_q     <= '0;
      done_q    <= '0;
      err_q     <= 1'b0;
      rd_data_q <= '0;
      busy_q    <= 1'b0;
      act_q     <= 1'b0;
      start_q   <= 1'b0;
      t_data_q  <= '0;
`ifdef MDIO_TIMEOUT_EN
      cnt_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      idx_q     <= idx_d;
      rd_q      <= rd_d;
      gnt_q     <= gnt_d;
      done_q    <= done_d;
      err_q     <= err_d;
      rd_data_q <= rd_data_d;
      busy_q    <= busy_d;
      act_q     <= act_d;
      start_q   <= start_d;
      t_data_q  <= t_data_d;
`ifdef MDIO_TIMEOUT_EN
      cnt_q     <= cnt_d;
`endif
    end
  end

  assign gnt             = gnt_q;
  assign done            = done_q;
  assign err             = err_q;
  assign rd_data         = rd_data_q;
  assign busy            = busy_q;
  assign mdio.activado   = act_q;
  assign mdio.mdio_start = start_q;
  assign mdio.t_data     = t_data_q;

endmodule

// File: tb/tb_mdio_arbiter.sv
// Self-checking bench for mdio_arbiter: directed scenarios plus randomized
// requests, checked against a transaction-level reference model (round-robin
// pick from a pointer, frame built arithmetically, read-data hold).
module tb_mdio_arbiter;
  localparam int unsigned N = 4;
`ifdef MDIO_TIMEOUT_EN
  localparam int unsigned TO = 16;
`else
  localparam int unsigned TO = 1024;
`endif

  logic             clk = 1'b0;
  logic             reset;
  logic [N-1:0]     req;
  logic [2*N-1:0]   req_op;
  logic [5*N-1:0]   req_phy;
  logic [5*N-1:0]   req_reg;
  logic [16*N-1:0]  req_wdata;
  logic [N-1:0]     gnt;
  logic [N-1:0]     done;
  logic             err;
  logic [15:0]      rd_data;
  logic             busy;

  mdio_arbiter_if bus ();

  mdio_arbiter #(.N_REQ(N), .TIMEOUT_CYC(TO)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .req_op    (req_op),
    .req_phy   (req_phy),
    .req_reg   (req_reg),
    .req_wdata (req_wdata),
    .gnt       (gnt),
    .done      (done),
    .err       (err),
    .rd_data   (rd_data),
    .busy      (busy),
    .mdio      (bus)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int          model_ptr;
  logic [15:0] exp_rd;
  logic [N-1:0] last_gnt;
  logic [31:0] last_tdata;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Clause-22 frame: ST=01, OP, PHYAD, REGAD, TA=10, DATA (zero for non-writes).
  function automatic logic [31:0] frame(input logic [1:0] op, input logic [4:0] p,
                                        input logic [4:0] r, input logic [15:0] w);
    int unsigned data;
    data = (op == 2'b01) ? 32'(w) : 32'd0;
    return (32'd1 << 30) + (32'(op) << 28) + (32'(p) << 23) + (32'(r) << 18)
           + (32'd2 << 16) + data;
  endfunction

  function automatic int rr_pick(input logic [N-1:0] r, input int p);
    for (int k = 0; k < int'(N); k++) begin
      int j;
      j = (p + k) % int'(N);
      if (r[j]) return j;
    end
    return -1;
  endfunction

  task automatic set_fields(input int i, input logic [1:0] op, input logic [4:0] p,
                            input logic [4:0] r, input logic [15:0] w);
    req_op[2*i +: 2]     = op;
    req_phy[5*i +: 5]    = p;
    req_reg[5*i +: 5]    = r;
    req_wdata[16*i +: 16] = w;
  endtask

  task automatic rand_fields(input int i);
    int unsigned v;
    logic [1:0] op;
    v  = $urandom_range(0, 9);
    op = (v < 4) ? 2'b01 : (v < 8) ? 2'b10 : (v == 8) ? 2'b00 : 2'b11;
    set_fields(i, op, 5'($urandom), 5'($urandom), 16'($urandom));
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_gnt"},   32'(gnt), 32'd0);
    chk({tag, "_done"},  32'(done), 32'd0);
    chk({tag, "_err"},   32'(err), 32'd0);
    chk({tag, "_rd"},    32'(rd_data), 32'd0);
    chk({tag, "_busy"},  32'(busy), 32'd0);
    chk({tag, "_act"},   32'(bus.activado), 32'd0);
    chk({tag, "_start"}, 32'(bus.mdio_start), 32'd0);
    chk({tag, "_tdata"}, bus.t_data, 32'd0);
  endtask

  // One transaction: caller sets req/fields in an IDLE cycle, returns in the
  // first IDLE cycle afterwards. lat = cycles between the first post-start
  // cycle and mdio_done; early = also pulse mdio_done during mdio_start.
  task automatic run_txn(input bit hold, input int lat, input bit early, input logic [15:0] cd);
    int w, n, l;
    logic [1:0] op;
    logic [31:0] f;
    bit valid;
    w = rr_pick(req, model_ptr);
    if (w < 0) return;
    op    = req_op[2*w +: 2];
    f     = frame(op, req_phy[5*w +: 5], req_reg[5*w +: 5], req_wdata[16*w +: 16]);
    valid = (op == 2'b01) || (op == 2'b10);
    model_ptr = (w + 1) % int'(N);
    l = lat;
`ifdef MDIO_TIMEOUT_EN
    if (l > 12) l = 12;
`endif
    n = 0;
    tick();
    while (gnt === '0 && n < 8) begin
      tick();
      n++;
    end
    chk("gnt",      32'(gnt), 32'(1) << w);
    chk("t_data",   bus.t_data, f);
    chk("busy_gnt", 32'(busy), 32'd1);
    chk("start",    32'(bus.mdio_start), 32'(valid));
    chk("act",      32'(bus.activado), 32'(valid));
    chk("done_gnt", 32'(done), 32'd0);
    last_gnt   = gnt;
    last_tdata = bus.t_data;
    if (!hold) req[w] = 1'b0;
    rand_fields(w);
    if (early) bus.mdio_done = 1'b1;
    tick();
    bus.mdio_done = 1'b0;
    chk("gnt_pulse",   32'(gnt), 32'd0);
    chk("start_pulse", 32'(bus.mdio_start), 32'd0);
    chk("t_data_hold", bus.t_data, f);
    if (!valid) begin
      chk("bad_done", 32'(done), 32'(1) << w);
      chk("bad_err",  32'(err), 32'd1);
      chk("bad_act",  32'(bus.activado), 32'd0);
      tick();
      chk("bad_done_end", 32'(done), 32'd0);
      chk("bad_err_end",  32'(err), 32'd0);
      chk("bad_busy_end", 32'(busy), 32'd0);
    end else begin
      chk("early_done", 32'(done), 32'd0);
      chk("act_wait",   32'(bus.activado), 32'd1);
      repeat (l) tick();
      bus.mdio_done    = 1'b1;
      bus.ctrl_rd_data = cd;
      tick();
      bus.mdio_done    = 1'b0;
      bus.ctrl_rd_data = 16'($urandom);
      if (op == 2'b10) exp_rd = cd;
      chk("done",      32'(done), 32'(1) << w);
      chk("err",       32'(err), 32'd0);
      chk("rd_data",   32'(rd_data), 32'(exp_rd));
      chk("act_done",  32'(bus.activado), 32'd0);
      chk("busy_gap",  32'(busy), 32'd1);
      tick();
      chk("done_end",  32'(done), 32'd0);
      chk("busy_end",  32'(busy), 32'd0);
      chk("rd_hold",   32'(rd_data), 32'(exp_rd));
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N-1:0] r;
    logic any_done;
    reset = 1'b1;
    req = '0; req_op = '0; req_phy = '0; req_reg = '0; req_wdata = '0;
    bus.mdio_done = 1'b0;
    bus.ctrl_rd_data = '0;
    model_ptr = 0;
    exp_rd = '0;
    last_gnt = '0;
    last_tdata = '0;
    repeat (3) tick();
    check_all_zero("reset");
    reset = 1'b0;
    tick();

    // Stray mdio_done in IDLE is ignored.
    bus.mdio_done = 1'b1;
    tick();
    bus.mdio_done = 1'b0;
    chk("idle_done", 32'(done), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);

    // Single read on requester 1, done 40 cycles after start.
    set_fields(1, 2'b10, 5'b00110, 5'b11110, 16'h1234);
    req = 4'b0010;
    run_txn(1'b0, 39, 1'b0, 16'h746E);
    chk("read_frame", last_tdata, 32'h637A0000);
    chk("read_gnt",   32'(last_gnt), 32'h2);
    chk("read_data",  32'(rd_data), 32'h746E);

    // Write on requester 0: rd_data must hold.
    set_fields(0, 2'b01, 5'd1, 5'd0, 16'hBEEF);
    req = 4'b0001;
    run_txn(1'b0, 5, 1'b1, 16'h5555);
    chk("write_frame", last_tdata, 32'h5082BEEF);
    chk("write_rd",    32'(rd_data), 32'h746E);

    // Bad opcode on requester 3 (also leaves pointer at 0).
    set_fields(3, 2'b11, 5'd7, 5'd9, 16'hAAAA);
    req = 4'b1000;
    run_txn(1'b0, 0, 1'b1, 16'h0);
    chk("bad_gnt", 32'(last_gnt), 32'h8);

    // Round-robin with req held: 0, 2, 0, 2.
    set_fields(0, 2'b10, 5'd3, 5'd4, 16'h0);
    set_fields(2, 2'b01, 5'd5, 5'd6, 16'hC0DE);
    req = 4'b0101;
    for (int k = 0; k < 4; k++) begin
      run_txn(1'b1, int'($urandom_range(0, 5)), k[0], 16'($urandom));
      chk("rr_order", 32'(last_gnt), (k % 2 == 0) ? 32'h1 : 32'h4);
    end
    req = '0;

    // Randomized requests.
    for (int t = 0; t < 40; t++) begin
      r = 4'($urandom_range(1, 15));
      for (int i = 0; i < int'(N); i++) rand_fields(i);
      req = r;
      run_txn(1'b0, int'($urandom_range(0, 12)), 1'($urandom), 16'($urandom));
    end

    // Reset during WAIT abandons the transaction.
    set_fields(1, 2'b10, 5'd2, 5'd3, 16'h0);
    req = 4'b0010;
    tick();
    chk("rst_txn_gnt", 32'(gnt), 32'(1) << rr_pick(4'b0010, model_ptr));
    req = '0;
    repeat (10) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_all_zero("midrst");
    model_ptr = 0;
    exp_rd = '0;
    bus.mdio_done = 1'b1;
    any_done = 1'b0;
    repeat (3) begin
      tick();
      bus.mdio_done = 1'b0;
      any_done = any_done | (|done);
    end
    chk("midrst_nodone", 32'(any_done), 32'd0);
    set_fields(0, 2'b10, 5'd8, 5'd9, 16'h0);
    set_fields(3, 2'b01, 5'd10, 5'd11, 16'h1111);
    req = 4'b1001;
    run_txn(1'b0, 3, 1'b0, 16'h0F0F);
    chk("post_rst_gnt", 32'(last_gnt), 32'h1);

`ifdef MDIO_TIMEOUT_EN
    // Timeout: no mdio_done; done/err 17 cycles after the req is seen.
    req = '0;
    set_fields(2, 2'b10, 5'd1, 5'd2, 16'h0);
    req = 4'b0100;
    tick();
    chk("to_gnt", 32'(gnt), 32'h4);
    model_ptr = 3;
    req = '0;
    any_done = 1'b0;
    repeat (15) begin
      tick();
      any_done = any_done | (|done);
    end
    chk("to_early", 32'(any_done), 32'd0);
    tick();
    chk("to_done", 32'(done), 32'h4);
    chk("to_err",  32'(err), 32'd1);
    chk("to_act",  32'(bus.activado), 32'd0);
    chk("to_rd",   32'(rd_data), 32'(exp_rd));
    bus.mdio_done = 1'b1;
    bus.ctrl_rd_data = 16'hDEAD;
    tick();
    bus.mdio_done = 1'b0;
    chk("to_end_done", 32'(done), 32'd0);
    chk("to_end_busy", 32'(busy), 32'd0);
    tick();
    chk("to_late_done", 32'(done), 32'd0);
    chk("to_late_rd",   32'(rd_data), 32'(exp_rd));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
